des_iter_core: RTL

Parametrised, iterative DES engine that encrypts or decrypts one 64-bit block per transaction using a registered datapath and a rolling key schedule. ROUNDS_PER_CYCLE trades area against latency, from 1 round per clock up to a fully unrolled 16 rounds per clock. The engine sits between a block-mode controller (ECB/CBC wrapper) and the system bus. Both sides use valid/ready handshakes, and a per-block MODE bit selects the direction.

---
 rtl/des_pkg.sv | 151 +++++++++++++++
 rtl/des_iter_core_round.sv | 30 +++
 rtl/des_iter_core.sv | 138 +++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: permutation index tables (1-based, MSB-first), S-boxes,
// key-schedule rotations, FSM state type and the permutation/round helpers.
package des_pkg;

    localparam int unsigned BLK_W  = 64;
    localparam int unsigned HALF_W = 32;
    localparam int unsigned KH_W   = 28;
    localparam int unsigned SUBK_W = 48;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Each box is row-major: index = {b1, b6, b2..b5}.
    localparam int unsigned SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // Rotation applied to C/D before each round; decrypt walks the schedule backwards.
    localparam int unsigned SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int unsigned SHIFT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) res = {res[62:0], 1'(x >> (64 - IP_T[i]))};
        return res;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) res = {res[62:0], 1'(x >> (64 - FP_T[i]))};
        return res;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] res;
        res = '0;
        for (int i = 0; i < 56; i++) res = {res[54:0], 1'(x >> (64 - PC1_T[i]))};
        return res;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] res;
        res = '0;
        for (int i = 0; i < 48; i++) res = {res[46:0], 1'(x >> (56 - PC2_T[i]))};
        return res;
    endfunction

    function automatic logic [47:0] des_e(input logic [31:0] x);
        logic [47:0] res;
        res = '0;
        for (int i = 0; i < 48; i++) res = {res[46:0], 1'(x >> (32 - E_T[i]))};
        return res;
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] x);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) res = {res[30:0], 1'(x >> (32 - P_T[i]))};
        return res;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [5:0]  six;
        logic [31:0] res;
        x   = des_e(r) ^ k;
        res = '0;
        for (int s = 0; s < 8; s++) begin
            six = 6'(x >> (42 - 6 * s));
            res = {res[27:0], 4'(SBOX[3'(s)][{six[5], six[0], six[4:1]}])};
        end
        return des_p(res);
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                          input logic right);
        case ({right, amt})
            3'b0_01: return {x[26:0], x[27]};
            3'b0_10: return {x[25:0], x[27:26]};
            3'b1_01: return {x[0], x[27:1]};
            3'b1_10: return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_iter_core_round.sv
// One combinational Feistel round including the C/D rotation that precedes it.
module des_round_unit
    import des_pkg::*;
(
    input  logic [HALF_W-1:0] i_l,
    input  logic [HALF_W-1:0] i_r,
    input  logic [KH_W-1:0]   i_c,
    input  logic [KH_W-1:0]   i_d,
    input  logic [3:0]        i_round,
    input  logic              i_mode,
    output logic [HALF_W-1:0] o_l_c,
    output logic [HALF_W-1:0] o_r_c,
    output logic [KH_W-1:0]   o_c_c,
    output logic [KH_W-1:0]   o_d_c
);
    logic [1:0]        w_shift;
    logic [KH_W-1:0]   w_c;
    logic [KH_W-1:0]   w_d;
    logic [SUBK_W-1:0] w_subkey;

    assign w_shift  = i_mode ? 2'(SHIFT_DEC[i_round]) : 2'(SHIFT_ENC[i_round]);
    assign w_c      = rot28(i_c, w_shift, i_mode);
    assign w_d      = rot28(i_d, w_shift, i_mode);
    assign w_subkey = des_pc2({w_c, w_d});

    assign o_l_c = i_r;
    assign o_r_c = i_l ^ des_f(i_r, w_subkey);
    assign o_c_c = w_c;
    assign o_d_c = w_d;
endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: ROUNDS_PER_CYCLE chained rounds per RUN cycle,
// valid/ready on both sides, registered result.
module des_iter_core
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_mode,
    input  logic [BLK_W-1:0] i_key,
    input  logic [BLK_W-1:0] i_data_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [BLK_W-1:0] o_data_out,
    output logic             o_busy
);
    localparam int unsigned N_CYC = 16 / ROUNDS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N_CYC + 1);
    localparam int unsigned RPC   = ROUNDS_PER_CYCLE;

    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t             r_state;
    state_t             w_next;
    logic [HALF_W-1:0]  r_l, r_r;
    logic [KH_W-1:0]    r_c, r_d;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic [BLK_W-1:0]   r_data_out;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_in_ready, w_accept, w_last;
    logic [BLK_W-1:0]   w_ip;
    logic [55:0]        w_pc1;
    logic [HALF_W-1:0]  w_l [RPC+1];
    logic [HALF_W-1:0]  w_r [RPC+1];
    logic [KH_W-1:0]    w_c [RPC+1];
    logic [KH_W-1:0]    w_d [RPC+1];
    logic [3:0]         w_round [RPC];

    assign w_l[0] = r_l;
    assign w_r[0] = r_r;
    assign w_c[0] = r_c;
    assign w_d[0] = r_d;

    for (genvar j = 0; j < RPC; j++) begin : g_round
        assign w_round[j] = 4'(32'(r_cnt) * RPC + 32'(j));
        des_round_unit u_round (
            .i_l    (w_l[j]),
            .i_r    (w_r[j]),
            .i_c    (w_c[j]),
            .i_d    (w_d[j]),
            .i_round(w_round[j]),
            .i_mode (r_mode),
            .o_l_c  (w_l[j+1]),
            .o_r_c  (w_r[j+1]),
            .o_c_c  (w_c[j+1]),
            .o_d_c  (w_d[j+1])
        );
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_RUN;
            ST_RUN:  if (w_last)   w_next = ST_DONE;
            ST_DONE: if (i_out_ready) w_next = w_accept ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake and control decode
    always_comb begin
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_last     = 1'b0;
        w_in_ready = !i_rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && i_out_ready));
        w_accept   = i_in_valid && w_in_ready;
        w_last     = (r_state == ST_RUN) && (r_cnt == CNT_W'(N_CYC - 1));
    end

    assign w_ip  = des_ip(i_data_in);
    assign w_pc1 = des_pc1(i_key);

    // Datapath and output register; final swap happens by feeding {R16, L16} to FP
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_l         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_l    <= w_ip[63:32];
                r_r    <= w_ip[31:0];
                r_c    <= w_pc1[55:28];
                r_d    <= w_pc1[27:0];
                r_cnt  <= '0;
                r_mode <= i_mode;
            end else if (r_state == ST_RUN) begin
                r_l   <= w_l[RPC];
                r_r   <= w_r[RPC];
                r_c   <= w_c[RPC];
                r_d   <= w_d[RPC];
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_data_out  <= des_fp({w_r[RPC], w_l[RPC]});
                r_out_valid <= 1'b1;
            end else if ((r_state == ST_DONE) && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_busy <= (w_next == ST_RUN);
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_data_out  = r_data_out;
    assign o_busy      = r_busy;
endmodule
